// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, 7/8 data bits LSB first, optional parity,
// configurable stop period, all paced by a shared 16x oversampling tick.
module uart_transmitter #(
  parameter int DBITS      = 8,
  parameter int SB_TICKS   = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_ticks,
  input  logic       tx_start,
  input  logic [7:0] din,
  output logic       tx,
  output logic       tx_ready,
  output logic       tx_done_tick
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  localparam logic [4:0] S_BIT  = 5'd15;
  localparam logic [4:0] S_STOP = 5'(SB_TICKS - 1);
  localparam logic [2:0] N_LAST = 3'(DBITS - 1);

  state_e     state_q;
  logic [4:0] s_q;
  logic [2:0] n_q;
  logic [7:0] b_q;
  logic       par_q;
  logic       tx_q;
  logic       rdy_q;
  logic       done_q;
  logic       par_d;

  assign par_d = (^din[DBITS-1:0]) ^ 1'(PARITY_ODD);

  assign tx           = tx_q;
  assign tx_ready     = rdy_q;
  assign tx_done_tick = done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      rdy_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (tx_start) begin
            b_q     <= din;
            par_q   <= par_d;
            s_q     <= '0;
            tx_q    <= 1'b0;
            rdy_q   <= 1'b0;
            state_q <= START;
          end else begin
            rdy_q <= 1'b1;
          end
        end
        START: begin
          if (s_ticks) begin
            if (s_q == S_BIT) begin
              s_q     <= '0;
              n_q     <= '0;
              tx_q    <= b_q[0];
              state_q <= DATA;
            end else begin
              s_q <= s_q + 5'd1;
            end
          end
        end
        DATA: begin
          if (s_ticks) begin
            if (s_q == S_BIT) begin
              s_q <= '0;
              b_q <= b_q >> 1;
              // b_q[1] is the next bit once the shift lands
              if (n_q == N_LAST) begin
                if (PARITY_EN != 0) begin
                  tx_q    <= par_q;
                  state_q <= PARITY;
                end else begin
                  tx_q    <= 1'b1;
                  state_q <= STOP;
                end
              end else begin
                n_q  <= n_q + 3'd1;
                tx_q <= b_q[1];
              end
            end else begin
              s_q <= s_q + 5'd1;
            end
          end
        end
        PARITY: begin
          if (s_ticks) begin
            if (s_q == S_BIT) begin
              s_q     <= '0;
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              s_q <= s_q + 5'd1;
            end
          end
        end
        STOP: begin
          if (s_ticks) begin
            if (s_q == S_STOP) begin
              // ready rises one cycle later so it never overlaps done
              s_q     <= '0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              s_q <= s_q + 5'd1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench: five transmitter configurations against a
// frame-level model derived from tick counts since acceptance.
module tb_uart_transmitter;

  localparam int ND = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [ND-1:0] start;
  logic [ND-1:0] tick;
  logic [7:0]    din [ND];
  logic [ND-1:0] tx;
  logic [ND-1:0] rdy;
  logic [ND-1:0] done;

  int cfg_db [ND] = '{8, 8, 8, 8, 7};
  int cfg_pe [ND] = '{0, 1, 1, 0, 1};
  int cfg_po [ND] = '{0, 0, 1, 0, 1};
  int cfg_sb [ND] = '{16, 16, 16, 32, 16};

  int n_chk = 0;
  int n_fail = 0;
  int cnt = 0;
  int per = 1;
  bit last_tick;

  always #5 clk = ~clk;

  uart_transmitter #(.DBITS(8), .SB_TICKS(16), .PARITY_EN(0),
                     .PARITY_ODD(0)) u0 (
    .clk(clk), .reset(reset), .s_ticks(tick[0]), .tx_start(start[0]),
    .din(din[0]), .tx(tx[0]), .tx_ready(rdy[0]), .tx_done_tick(done[0]));
  uart_transmitter #(.DBITS(8), .SB_TICKS(16), .PARITY_EN(1),
                     .PARITY_ODD(0)) u1 (
    .clk(clk), .reset(reset), .s_ticks(tick[1]), .tx_start(start[1]),
    .din(din[1]), .tx(tx[1]), .tx_ready(rdy[1]), .tx_done_tick(done[1]));
  uart_transmitter #(.DBITS(8), .SB_TICKS(16), .PARITY_EN(1),
                     .PARITY_ODD(1)) u2 (
    .clk(clk), .reset(reset), .s_ticks(tick[2]), .tx_start(start[2]),
    .din(din[2]), .tx(tx[2]), .tx_ready(rdy[2]), .tx_done_tick(done[2]));
  uart_transmitter #(.DBITS(8), .SB_TICKS(32), .PARITY_EN(0),
                     .PARITY_ODD(0)) u3 (
    .clk(clk), .reset(reset), .s_ticks(tick[3]), .tx_start(start[3]),
    .din(din[3]), .tx(tx[3]), .tx_ready(rdy[3]), .tx_done_tick(done[3]));
  uart_transmitter #(.DBITS(7), .SB_TICKS(16), .PARITY_EN(1),
                     .PARITY_ODD(1)) u4 (
    .clk(clk), .reset(reset), .s_ticks(tick[4]), .tx_start(start[4]),
    .din(din[4]), .tx(tx[4]), .tx_ready(rdy[4]), .tx_done_tick(done[4]));

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    tick = (cnt % per == 0) ? '1 : '0;
    last_tick = tick[0];
    @(posedge clk);
    #1;
    cnt++;
  endtask

  // Expected line after T ticks: segment T/16 of the bit list, then stop,
  // with done exactly when the last stop tick has been counted.
  task automatic send(input int d, input logic [7:0] data, input bit hold,
                      input int inj_t, input int rst_t);
    int nb, total, t;
    logic [15:0] bits;
    logic par;
    nb = 1 + cfg_db[d] + cfg_pe[d];
    total = 16 * nb + cfg_sb[d];
    bits = '1;
    bits[0] = 1'b0;
    par = cfg_po[d][0];
    for (int i = 0; i < cfg_db[d]; i++) begin
      bits[1+i] = data[i];
      par ^= data[i];
    end
    if (cfg_pe[d] != 0) bits[nb-1] = par;
    if (!hold) begin
      start[d] = 1'b0;
      while (cnt % per != 0) step();
    end
    start[d] = 1'b1;
    din[d] = data;
    step();
    chk("accept_tx", tx[d], 0);
    chk("accept_rdy", rdy[d], 0);
    start[d] = hold;
    din[d] = 8'($urandom);
    t = 0;
    while (t < total) begin
      if (inj_t >= 0 && t == inj_t) begin
        start[d] = 1'b1;
        din[d] = 8'hFF;
      end else if (!hold) begin
        start[d] = 1'b0;
      end
      if (rst_t >= 0 && t == rst_t) reset = 1'b1;
      step();
      if (reset) begin
        reset = 1'b0;
        start[d] = 1'b0;
        chk("abort_tx", tx[d], 1);
        chk("abort_rdy", rdy[d], 1);
        chk("abort_done", done[d], 0);
        return;
      end
      if (last_tick) t++;
      chk("frame_tx", tx[d], (t >= 16 * nb) ? 1 : 32'(bits[t/16]));
      chk("frame_done", done[d], (t == total) ? 1 : 0);
      chk("frame_rdy", rdy[d], 0);
    end
    if (!hold) begin
      start[d] = 1'b0;
      step();
      chk("post_tx", tx[d], 1);
      chk("post_rdy", rdy[d], 1);
      chk("post_done", done[d], 0);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = '0;
    tick = '0;
    for (int i = 0; i < ND; i++) din[i] = 8'h00;
    step();
    step();
    for (int i = 0; i < ND; i++) begin
      chk("rst_tx", tx[i], 1);
      chk("rst_rdy", rdy[i], 1);
      chk("rst_done", done[i], 0);
    end
    reset = 1'b0;
    step();

    send(0, 8'hA5, 1'b0, -1, -1);
    send(1, 8'h07, 1'b0, -1, -1);
    send(2, 8'h07, 1'b0, -1, -1);
    send(0, 8'hA5, 1'b0, 16 * 3 + 5, -1);

    send(0, 8'h96, 1'b0, -1, 16 * 4 + 8);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_done", done[0], 0);
      chk("idle_tx", tx[0], 1);
    end
    send(0, 8'h3C, 1'b0, -1, -1);

    per = 4;
    send(3, 8'($urandom), 1'b0, -1, -1);

    per = 1;
    send(0, 8'($urandom), 1'b1, -1, -1);
    send(0, 8'($urandom), 1'b1, -1, -1);
    send(0, 8'($urandom), 1'b0, -1, -1);

    for (int k = 0; k < 12; k++) begin
      per = $urandom_range(1, 3);
      send($urandom_range(0, ND - 1), 8'($urandom), 1'b0, -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 SHALL have parameter DBITS, default 8, meaning data bits per frame; legal values 7 or 8.
REQ-002 SHALL have parameter SB_TICKS, default 16, meaning s_ticks per stop period (16 = 1 stop bit, 24 = 1.5, 32 = 2).
REQ-003 SHALL have parameter PARITY_EN, default 0, meaning 1 inserts a parity bit after the data bits.
REQ-004 SHALL have parameter PARITY_ODD, default 0, meaning 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
REQ-005 SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port s_ticks, input, 1 bit: one-cycle enable at 16x the baud rate, from the shared baud generator.
REQ-008 SHALL have port tx_start, input, 1 bit: request to send din.
REQ-009 SHALL have port din, input, 8 bits: frame data; only din[DBITS-1:0] is sent.
REQ-010 SHALL have port tx, output, 1 bit: serial line, idle high, driven directly from a register.
REQ-011 SHALL have port tx_ready, output, 1 bit: high only in IDLE.
REQ-012 SHALL have port tx_done_tick, output, 1 bit: one-cycle pulse at the end of the stop period.

Function
REQ-013 SHALL implement the states IDLE, START, DATA, PARITY and STOP, with a tick counter s, a bit counter n and a shift register b.
REQ-014 In IDLE, tx_start=1 SHALL load b<=din, clear s and enter START; tx SHALL go low on the next cycle (1-cycle latency).
REQ-015 tx_start SHALL be ignored in every state except IDLE; din is sampled only on the accepting cycle.
REQ-016 s_ticks SHALL have no effect in IDLE; in all other states s SHALL advance only on cycles with s_ticks=1.
REQ-017 START SHALL hold tx=0 for 16 s_ticks; on the tick where s==15 it SHALL set s=0, n=0 and enter DATA.
REQ-018 DATA SHALL drive tx=b[0] for 16 s_ticks per bit, LSB first; on the tick where s==15 it SHALL shift b right by one and clear s.
REQ-019 DATA SHALL increment n after each bit; after bit n==DBITS-1 it SHALL enter PARITY if PARITY_EN=1, otherwise STOP.
REQ-020 The parity bit SHALL be the XOR of din[DBITS-1:0] computed at acceptance, inverted when PARITY_ODD=1.
REQ-021 PARITY SHALL drive the parity bit for 16 s_ticks, then enter STOP.
REQ-022 STOP SHALL drive tx=1 for SB_TICKS s_ticks; on the tick where s==SB_TICKS-1 it SHALL pulse tx_done_tick for that one cycle and return to IDLE.
REQ-023 The counter s SHALL be wide enough to hold SB_TICKS-1 (5 bits) and SHALL wrap only through explicit clears.
REQ-024 When tx_start is held high across the end of a frame, the next frame SHALL start on the first IDLE cycle, giving back-to-back frames with 1 idle clk.
REQ-025 tx_done_tick SHALL never assert in the same cycle as tx_ready.

Reset
REQ-026 When reset=1 at a clock edge, the block SHALL set state=IDLE, s=0, n=0, b=0, tx=1, tx_ready=1 and tx_done_tick=0 after that edge.
REQ-027 Reset mid-frame SHALL abort the frame: tx high on the next cycle, no tx_done_tick, and any in-flight data discarded.

Verification
REQ-028 Bench SHALL check: defaults, s_ticks every cycle, din=0xA5, 1-cycle tx_start -> tx bits 0,1,0,1,0,0,1,0,1,1, each 16 clk wide; tx_done_tick pulses exactly once, 160 clk after acceptance.
REQ-029 Bench SHALL check: PARITY_EN=1, PARITY_ODD=0, din=0x07 -> parity bit 1; PARITY_ODD=1 -> parity bit 0; frame is 11 bit periods.
REQ-030 Bench SHALL check: tx_start pulsed with din=0xFF while in DATA -> ignored; the current 0xA5 frame completes unchanged; tx_ready=0 throughout the frame.
REQ-031 Bench SHALL check: reset asserted during data bit 3 -> tx=1 and tx_ready=1 next cycle, no tx_done_tick; a new 0x3C frame then sends correctly.
REQ-032 Bench SHALL check: s_ticks every 4th clk, SB_TICKS=32 -> each bit 64 clk wide and the stop period 128 clk.
REQ-033 Bench SHALL check: tx_start held high continuously -> successive frames separated by exactly 1 idle clk with tx=1.
